// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor built around one full-adder stage
// and a registered carry. One result bit is produced per clock; operands and
// mode are captured on a start/ready handshake and the result is published
// with a one-cycle done pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; ready=1, last result held on sum/cout/overflow
// RUN   | one result bit per cycle, LSB first; busy=1, start ignored
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_nxt;

    // Single full-adder stage on the current LSBs and the carry register.
    assign s_bit = sa[0] ^ sb[0] ^ c;
    assign c_nxt = (sa[0] & sb[0]) | (sb[0] & c) | (sa[0] & c);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shift registers, carry, partial result and bit counter.
    // Subtraction is folded into the load: ~b with a carry-in of 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            sr  <= '0;
            c   <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            sa  <= a;
            sb  <= sub ? ~b : b;
            c   <= sub ? 1'b1 : cin;
            cnt <= '0;
        end else if (step) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= {s_bit, sr[WIDTH-1:1]};
            c   <= c_nxt;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    // Result registers: updated only on the final bit so partial sums never leak.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (last) begin
                sum      <= {s_bit, sr[WIDTH-1:1]};
                cout     <= c_nxt;
                overflow <= c ^ c_nxt;
                done     <= 1'b1;
            end
        end
    end

    // Handshake flags decode straight from the state flop.
    assign ready = (state == IDLE);
    assign busy  = (state == RUN);

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8). Accepted
// operations are modelled with plain arithmetic and queued; a negedge monitor
// pops and compares on every done pulse and checks held outputs otherwise.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    logic         rst_q = 1'b0;
    logic [W-1:0] hold_s = '0;
    logic         hold_co = 1'b0;
    logic         hold_ov = 1'b0;
    bit           b2b = 1'b0;
    int           b2b_start = 0;
    int           last_done = -1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic xcin, input logic xsub, input int acc);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   t;
        bb    = xsub ? ~xb : xb;
        t     = {1'b0, xa} + {1'b0, bb} + (xsub ? (W+1)'(1) : (W+1)'(xcin));
        e.s   = t[W-1:0];
        e.co  = t[W];
        e.ov  = (xa[W-1] == bb[W-1]) && (t[W-1] != xa[W-1]);
        e.acc = acc;
        return e;
    endfunction

    // Capture accepted requests into the scoreboard; reset discards pending work.
    always @(posedge clk) begin
        rst_q <= rst;
        cyc   <= cyc + 1;
        if (rst) begin
            q.delete();
        end else if (start && ready) begin
            q.push_back(model(a, b, cin, sub, cyc));
        end
    end

    // Monitor: compare on done, otherwise require results to be held.
    always @(negedge clk) begin
        exp_t e;
        chk("busy_not_ready", 32'(busy), 32'(!ready));
        if (rst_q) begin
            chk("rst_ready", 32'(ready), 32'd1);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_cout", 32'(cout), 32'd0);
            chk("rst_ovf", 32'(overflow), 32'd0);
            hold_s  = '0;
            hold_co = 1'b0;
            hold_ov = 1'b0;
        end else if (done) begin
            chk("done_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_sum", 32'(sum), 32'(e.s));
                chk("sb_cout", 32'(cout), 32'(e.co));
                chk("sb_ovf", 32'(overflow), 32'(e.ov));
                chk("sb_latency", cyc - e.acc, W + 1);
                hold_s  = e.s;
                hold_co = e.co;
                hold_ov = e.ov;
            end
            if (b2b && last_done >= b2b_start)
                chk("done_interval", cyc - last_done, W + 1);
            last_done = cyc;
        end else begin
            chk("sum_held", 32'(sum), 32'(hold_s));
            chk("cout_held", 32'(cout), 32'(hold_co));
            chk("ovf_held", 32'(overflow), 32'(hold_ov));
        end
    end

    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xcin, input logic xsub);
        @(posedge clk); #1;
        start = 1'b1; a = xa; b = xb; cin = xcin; sub = xsub;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < W + 6; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic run_dir(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic xcin, input logic xsub,
                           input logic [W-1:0] es, input logic eco, input logic eov);
        bit ok;
        issue(xa, xb, xcin, xsub);
        wait_done(ok);
        if (ok) begin
            chk({name, "_sum"}, 32'(sum), 32'(es));
            chk({name, "_cout"}, 32'(cout), 32'(eco));
            chk({name, "_ovf"}, 32'(overflow), 32'(eov));
        end
    endtask

    initial begin
        bit ok;
        // Reset held with start asserted and random operands.
        start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_sum", 32'(sum), 32'd0);

        // Directed boundary cases.
        run_dir("wrap",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_dir("cin",     8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        run_dir("ovf_add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_dir("sub_neg", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_dir("ovf_sub", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Random operations with random idle gaps.
        for (int i = 0; i < 25; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            wait_done(ok);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Start held high while operands churn every cycle.
        @(posedge clk); #1;
        b2b_start = cyc;
        b2b   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1;
        b2b = 1'b0;

        // Reset asserted on the 4th RUN cycle aborts the operation.
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        repeat (W + 2) @(negedge clk);
        run_dir("after_abort", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
